// File: rtl/memory_responder_pkg.sv
// Shared MMIO map for memory_responder: page base, register word offsets,
// STATUS bit positions and the address-region decode helper.
package memory_responder_pkg;

  // MMIO page base 0xFFFF_0000 expressed as a word address.
  localparam logic [29:0] MMIO_BASE_WORD = 30'h3FFF_C000;

  localparam logic [2:0] OFS_CONSOLE_DATA   = 3'd0;
  localparam logic [2:0] OFS_CONSOLE_STATUS = 3'd1;
  localparam logic [2:0] OFS_CYCLE_LO       = 3'd2;
  localparam logic [2:0] OFS_CYCLE_HI       = 3'd3;
  localparam logic [2:0] OFS_HALT           = 3'd4;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_CONSOLE_DATA,
    RGN_CONSOLE_STATUS,
    RGN_CYCLE_LO,
    RGN_CYCLE_HI,
    RGN_HALT
  } region_e;

  // Decodes the MMIO page only; RAM range is checked by the caller.
  function automatic region_e mmio_decode(input logic [29:0] addr);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr[29:3] == MMIO_BASE_WORD[29:3]) begin
      case (addr[2:0])
        OFS_CONSOLE_DATA:   rgn = RGN_CONSOLE_DATA;
        OFS_CONSOLE_STATUS: rgn = RGN_CONSOLE_STATUS;
        OFS_CYCLE_LO:       rgn = RGN_CYCLE_LO;
        OFS_CYCLE_HI:       rgn = RGN_CYCLE_HI;
        OFS_HALT:           rgn = RGN_HALT;
        default:            rgn = RGN_NONE;
      endcase
    end
    return rgn;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is the oldest entry.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is not reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Responder end of the CPU memory port: byte-writable RAM plus an MMIO page
// (console TX FIFO, 64-bit cycle counter, halt/exit register).
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int    RAM_WORDS  = 4096,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] address,
  input  logic [31:0] memory_in,
  input  logic [3:0]  write_enable,
  output logic [31:0] memory_out,
  output logic        read_capable,
  output logic        write_capable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [7:0]  exit_code
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0] r_mem [RAM_WORDS];
  logic [63:0] r_cycle;
  logic        r_halt;
  logic [7:0]  r_exit_code;
  logic        r_overflow;

  region_e     w_region;
  logic [RAM_AW-1:0] w_ram_idx;
  logic        w_any_we;
  logic [3:0]  w_lane_we;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_head;
  logic        w_push_req;
  logic        w_pop;
  logic        w_halt_wr;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_region = RGN_NONE;
    if ({2'b00, address} < 32'(RAM_WORDS)) begin
      w_region = RGN_RAM;
    end else begin
      w_region = mmio_decode(address);
    end
  end

  assign w_ram_idx     = address[RAM_AW-1:0];
  assign w_any_we      = |write_enable;
  assign read_capable  = (w_region != RGN_NONE);
  assign write_capable = (w_region == RGN_RAM) || (w_region == RGN_CONSOLE_DATA) ||
                         (w_region == RGN_HALT);

  // ------------------------------------------------------------------ reads
  always_comb begin
    memory_out = 32'd0;
    case (w_region)
      RGN_RAM:            memory_out = r_mem[w_ram_idx];
      RGN_CONSOLE_DATA:   memory_out = 32'd0;
      RGN_CONSOLE_STATUS: begin
        memory_out[STATUS_EMPTY_BIT]    = w_fifo_empty;
        memory_out[STATUS_FULL_BIT]     = w_fifo_full;
        memory_out[STATUS_OVERFLOW_BIT] = r_overflow;
      end
      RGN_CYCLE_LO:       memory_out = r_cycle[31:0];
      RGN_CYCLE_HI:       memory_out = r_cycle[63:32];
      RGN_HALT:           memory_out = {23'd0, r_halt, r_exit_code};
      default:            memory_out = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------- RAM
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_we[gi] = (w_region == RGN_RAM) && write_enable[gi];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_lane_we[k]) begin
        r_mem[w_ram_idx][k*8 +: 8] <= memory_in[k*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------- console FIFO
  assign w_push_req = (w_region == RGN_CONSOLE_DATA) && write_enable[0];
  assign w_pop      = !w_fifo_empty && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_req),
    .push_data (memory_in[7:0]),
    .pop       (w_pop),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (w_fifo_head)
  );

  assign tx_data  = w_fifo_head;
  assign tx_valid = !w_fifo_empty;

  // ---------------------------------------------- counter, overflow, halt
  assign w_halt_wr = (w_region == RGN_HALT) && write_enable[0] && w_any_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle     <= 64'd0;
      r_overflow  <= 1'b0;
      r_halt      <= 1'b0;
      r_exit_code <= 8'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      // A byte is lost only when full and nothing drains this cycle.
      if (w_push_req && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_halt_wr && !r_halt) begin
        r_halt      <= 1'b1;
        r_exit_code <= memory_in[7:0];
      end
    end
  end

  assign halt      = r_halt;
  assign exit_code = r_exit_code;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: read expectations and console bytes
// are queued by the stimulus and checked by an independent monitor.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] address = '0;
  logic [31:0] memory_in = '0;
  logic [3:0]  write_enable = '0;
  logic [31:0] memory_out;
  logic        read_capable;
  logic        write_capable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [7:0]  exit_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        rc;
    logic        wc;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  logic       rd_req = 1'b0;

  localparam logic [31:0] A_CDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_CSTAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLO = 32'hFFFF_0008;
  localparam logic [31:0] A_CYCHI = 32'hFFFF_000C;
  localparam logic [31:0] A_HALT  = 32'hFFFF_0010;

  memory_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .memory_in     (memory_in),
    .write_enable  (write_enable),
    .memory_out    (memory_out),
    .read_capable  (read_capable),
    .write_capable (write_capable),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .halt          (halt),
    .exit_code     (exit_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] baddr, input logic [31:0] d, input logic [3:0] we);
    address      = baddr[31:2];
    memory_in    = d;
    write_enable = we;
    tick();
    write_enable = 4'd0;
    $display("wr addr=%h data=%h we=%b", baddr, d, we);
  endtask

  task automatic rd(input logic [31:0] baddr, input logic [31:0] d, input logic rc,
                    input logic wc, input string name);
    rd_exp_t e;
    e.name = name;
    e.data = d;
    e.rc   = rc;
    e.wc   = wc;
    rd_q.push_back(e);
    address      = baddr[31:2];
    write_enable = 4'd0;
    rd_req       = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    rd_exp_t    e;
    logic [7:0] b;
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got data=%h want no read", memory_out);
      end else begin
        e = rd_q.pop_front();
        check({e.name, "_data"}, 64'(memory_out), 64'(e.data));
        check({e.name, "_rc"}, 64'(read_capable), 64'(e.rc));
        check({e.name, "_wc"}, 64'(write_capable), 64'(e.wc));
        $display("rd %s data=%h rc=%0b wc=%0b", e.name, memory_out, read_capable, write_capable);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got %h want no byte", tx_data);
      end else begin
        b = tx_q.pop_front();
        check("tx_byte", 64'(tx_data), 64'(b));
        $display("tx byte=%h", tx_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_exit", 64'(exit_code), 64'd0);
    rd(A_CSTAT, 32'h1, 1'b1, 1'b0, "rst_status");
    rd(A_CYCLO, 32'h0, 1'b1, 1'b0, "rst_cyc_lo");

    // Cycle counter after release
    rst_n = 1'b1;
    repeat (5) tick();
    rd(A_CYCLO, 32'd5, 1'b1, 1'b0, "cyc_lo_5");
    rd(A_CYCHI, 32'd0, 1'b1, 1'b0, "cyc_hi_0");
    wr(A_CYCHI, 32'hFFFF_FFFF, 4'b1111);
    rd(A_CYCHI, 32'd0, 1'b1, 1'b0, "cyc_hi_ro");

    // Unmapped and RAM boundary
    rd(32'h2000_0000, 32'd0, 1'b0, 1'b0, "unmapped");
    rd(32'h0000_4000, 32'd0, 1'b0, 1'b0, "ram_end");
    rd(32'hFFFF_0014, 32'd0, 1'b0, 1'b0, "mmio_hole");

    // RAM byte lanes
    wr(32'h10, 32'hAABB_CCDD, 4'b1111);
    wr(32'h10, 32'h0011_0000, 4'b0100);
    rd(32'h10, 32'hAA11_CCDD, 1'b1, 1'b1, "ram_lane2");
    wr(32'h14, 32'h1122_3344, 4'b1111);
    wr(32'h14, 32'h5566_7788, 4'b1001);
    rd(32'h14, 32'h5522_3388, 1'b1, 1'b1, "ram_lane03");
    wr(32'h3FFC, 32'h1234_5678, 4'b1111);
    rd(32'h3FFC, 32'h1234_5678, 1'b1, 1'b1, "ram_last");

    // Counter wrap
    force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_cycle;
    rd(A_CYCHI, 32'hFFFF_FFFF, 1'b1, 1'b0, "cyc_hi_max");
    rd(A_CYCLO, 32'd0, 1'b1, 1'b0, "cyc_lo_wrap");
    rd(A_CYCHI, 32'd0, 1'b1, 1'b0, "cyc_hi_wrap");

    // Console: lane 1 alone does not push
    rd(A_CDATA, 32'd0, 1'b1, 1'b1, "cdata_rd");
    wr(A_CDATA, 32'h41, 4'b0010);
    rd(A_CSTAT, 32'h1, 1'b1, 1'b0, "lane1_nopush");

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      wr(A_CDATA, 32'h41 + 32'(i), 4'b0001);
    end
    wr(A_CDATA, 32'h49, 4'b0001);
    rd(A_CSTAT, 32'h6, 1'b1, 1'b0, "status_ovf_full");
    tx_ready = 1'b1;
    repeat (8) tick();
    check("drain_tx_valid", 64'(tx_valid), 64'd0);
    check("drain_q_left", 64'(tx_q.size()), 64'd0);
    rd(A_CSTAT, 32'h5, 1'b1, 1'b0, "status_ovf_empty");

    // Halt
    wr(A_HALT, 32'h2A, 4'b0001);
    check("halt_set", 64'(halt), 64'd1);
    check("exit_set", 64'(exit_code), 64'h2A);
    rd(A_HALT, 32'h12A, 1'b1, 1'b1, "halt_rd");
    wr(A_HALT, 32'h07, 4'b0001);
    check("exit_sticky", 64'(exit_code), 64'h2A);
    rd(A_HALT, 32'h12A, 1'b1, 1'b1, "halt_rd2");
    wr(32'h20, 32'hCAFE_F00D, 4'b1111);
    rd(32'h20, 32'hCAFE_F00D, 1'b1, 1'b1, "ram_after_halt");

    // Reset mid-operation
    tx_ready = 1'b0;
    tx_q.push_back(8'h71);
    wr(A_CDATA, 32'h71, 4'b0001);
    check("pre_rst_valid", 64'(tx_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_halt", 64'(halt), 64'd0);
    check("async_valid", 64'(tx_valid), 64'd0);
    check("async_exit", 64'(exit_code), 64'd0);
    tx_q.delete();
    tick();
    rst_n = 1'b1;
    rd(A_CSTAT, 32'h1, 1'b1, 1'b0, "status_after_rst");

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h61 + 8'(i));
      wr(A_CDATA, 32'h61 + 32'(i), 4'b0001);
    end
    rd(A_CSTAT, 32'h2, 1'b1, 1'b0, "status_full");
    tx_ready = 1'b1;
    tx_q.push_back(8'h5A);
    wr(A_CDATA, 32'h5A, 4'b0001);
    rd(A_CSTAT, 32'h2, 1'b1, 1'b0, "status_full_swap");
    repeat (7) tick();
    check("swap_tx_valid", 64'(tx_valid), 64'd0);
    rd(A_CSTAT, 32'h1, 1'b1, 1'b0, "status_no_ovf");
    check("swap_q_left", 64'(tx_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
